// File: rtl/tile_index_ram.sv
// Background tile-index store: byte-enabled CPU port, scanout read port and a fill engine.
// Optional scanout scroll offsets are enabled by defining TILE_INDEX_RAM_SCROLL_EN.
module tile_index_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6,
    parameter int COL_W  = 3
) (
    input  logic                     clk_clk,
    input  logic                     reset_reset_n,
    input  logic [ADDR_W-1:0]        s1_address,
    input  logic                     s1_chipselect,
    input  logic                     s1_read,
    input  logic                     s1_write,
    input  logic [DATA_W-1:0]        s1_writedata,
    input  logic [DATA_W/8-1:0]      s1_byteenable,
    output logic [DATA_W-1:0]        s1_readdata,
    output logic                     s1_readdatavalid,
    output logic                     s1_waitrequest,
    input  logic                     clr_start,
    input  logic [DATA_W-1:0]        clr_value,
    output logic                     clr_busy,
    input  logic                     disp_req,
    input  logic [ADDR_W-1:0]        disp_addr,
    output logic [DATA_W-1:0]        disp_data,
    output logic                     disp_valid
`ifdef TILE_INDEX_RAM_SCROLL_EN
    ,
    input  logic [COL_W-1:0]         scroll_x,
    input  logic [ADDR_W-COL_W-1:0]  scroll_y
`endif
);

    localparam int BE_W  = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;
    localparam int ROW_W = ADDR_W - COL_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_start;
    logic [ADDR_W-1:0]   r_cnt;
    logic [DATA_W-1:0]   r_fill;

    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_cpu_wr;
    logic                w_cpu_rd;
    logic                w_we;
    logic [ADDR_W-1:0]   w_waddr;
    logic [DATA_W-1:0]   w_wdata;
    logic [BE_W-1:0]     w_wbe;
    logic [ADDR_W-1:0]   w_disp_addr;
    logic [DATA_W-1:0]   r_s1_readdata;
    logic                r_s1_readdatavalid;
    logic [DATA_W-1:0]   r_disp_data;
    logic                r_disp_valid;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (clr_start) begin
                    w_state_nxt = ST_CLEAR;
                    w_start     = 1'b1;
                end
            end
            ST_CLEAR: begin
                if (r_cnt == LAST_ADDR) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Counter wraps naturally to 0 after the last address is written.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_cnt  <= '0;
            r_fill <= '0;
        end else if (w_start) begin
            r_cnt  <= '0;
            r_fill <= clr_value;
        end else if (r_state == ST_CLEAR) begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    assign clr_busy       = (r_state == ST_CLEAR);
    assign s1_waitrequest = s1_chipselect & clr_busy;

    assign w_cpu_wr = s1_chipselect & s1_write & ~s1_waitrequest;
    assign w_cpu_rd = s1_chipselect & s1_read & ~s1_write & ~s1_waitrequest;

    // CPU is stalled throughout a clear, so the clear engine owns the write port then.
    assign w_we    = clr_busy | w_cpu_wr;
    assign w_waddr = clr_busy ? r_cnt  : s1_address;
    assign w_wdata = clr_busy ? r_fill : s1_writedata;
    assign w_wbe   = clr_busy ? {BE_W{1'b1}} : s1_byteenable;

    always_ff @(posedge clk_clk) begin
        if (w_we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (w_wbe[b]) begin
                    r_mem[w_waddr][b*8 +: 8] <= w_wdata[b*8 +: 8];
                end
            end
        end
    end

`ifdef TILE_INDEX_RAM_SCROLL_EN
    logic [ROW_W-1:0] w_row;
    logic [COL_W-1:0] w_col;
    // Row and column wrap separately; no carry from column into row.
    assign w_row       = disp_addr[ADDR_W-1:COL_W] + scroll_y;
    assign w_col       = disp_addr[COL_W-1:0] + scroll_x;
    assign w_disp_addr = {w_row, w_col};
`else
    assign w_disp_addr = disp_addr;
`endif

    // Reads sample the array before the same-edge write lands, returning old data.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_s1_readdata      <= '0;
            r_s1_readdatavalid <= 1'b0;
            r_disp_data        <= '0;
            r_disp_valid       <= 1'b0;
        end else begin
            r_s1_readdatavalid <= w_cpu_rd;
            r_disp_valid       <= disp_req;
            if (w_cpu_rd) begin
                r_s1_readdata <= r_mem[s1_address];
            end
            if (disp_req) begin
                r_disp_data <= r_mem[w_disp_addr];
            end
        end
    end

    assign s1_readdata      = r_s1_readdata;
    assign s1_readdatavalid = r_s1_readdatavalid;
    assign disp_data        = r_disp_data;
    assign disp_valid       = r_disp_valid;

endmodule
